// File: rtl/mips_timer_pkg.sv
// Shared constants for the memory-mapped MIPS timer: register offsets,
// CTRL bit positions, reset values and the run-state encoding.
package mips_timer_pkg;

  // Word offsets, i.e. memaddr[4:2]
  localparam logic [2:0] TMR_CTRL     = 3'd0;
  localparam logic [2:0] TMR_PRESCALE = 3'd1;
  localparam logic [2:0] TMR_COUNT    = 3'd2;
  localparam logic [2:0] TMR_COMPARE  = 3'd3;
  localparam logic [2:0] TMR_STATUS   = 3'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQEN  = 2;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/mips_timer_prescaler.sv
// Clock divider for the timer: emits a one-cycle tick every div+1 cycles
// while run is high.
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  assign tick = run & (pcnt_q == div);

  // Held at zero while idle, so every enable starts a full period.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clr || !run || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/mips_timer.sv
// Timer responder on the single-cycle MIPS data bus: register window,
// prescaled COUNT vs COMPARE matching, sticky match flag and irq.
module mips_timer
  import mips_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq
);

  tmr_state_e            state_q, state_d;
  logic                  reload_q, reload_d;
  logic                  irqen_q, irqen_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic                  match_q, match_d;

  logic [2:0]  offset;
  logic        we;
  logic        wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic        tick;
  logic        cmp_eq;
  logic [31:0] prescale_rd;
  logic        unused_addr_lsb;

  assign hit             = (memaddr[31:5] == BASE_ADDR[31:5]);
  assign offset          = memaddr[4:2];
  assign we              = memwrite & hit;
  assign wr_ctrl         = we & (offset == TMR_CTRL);
  assign wr_prescale     = we & (offset == TMR_PRESCALE);
  assign wr_count        = we & (offset == TMR_COUNT);
  assign wr_compare      = we & (offset == TMR_COMPARE);
  assign wr_status       = we & (offset == TMR_STATUS);
  assign cmp_eq          = (count_q == compare_q);
  assign irq             = match_q & irqen_q;
  assign unused_addr_lsb = ^memaddr[1:0];

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == ST_RUN),
    .clr   (wr_prescale),
    .div   (prescale_q),
    .tick  (tick)
  );

  // A CPU write to CTRL overrides the one-shot auto-stop in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_ctrl && memwritedata[CTRL_EN]) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wr_ctrl) begin
          state_d = memwritedata[CTRL_EN] ? ST_RUN : ST_IDLE;
        end else if (tick && cmp_eq && !reload_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Order matters: W1C before the hardware set, CPU writes after the tick.
  always_comb begin
    reload_d   = reload_q;
    irqen_d    = irqen_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;

    if (wr_status && memwritedata[0]) begin
      match_d = 1'b0;
    end

    if (tick) begin
      if (cmp_eq) begin
        match_d = 1'b1;
        if (reload_q) begin
          count_d = '0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_ctrl) begin
      reload_d = memwritedata[CTRL_RELOAD];
      irqen_d  = memwritedata[CTRL_IRQEN];
    end
    if (wr_prescale) begin
      prescale_d = memwritedata[PRESCALE_W-1:0];
    end
    if (wr_count) begin
      count_d = memwritedata;
    end
    if (wr_compare) begin
      compare_d = memwritedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      reload_q   <= 1'b0;
      irqen_q    <= 1'b0;
      prescale_q <= '0;
      count_q    <= '0;
      compare_q  <= COMPARE_RST;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      reload_q   <= reload_d;
      irqen_q    <= irqen_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
    end
  end

  always_comb begin
    prescale_rd                   = '0;
    prescale_rd[PRESCALE_W-1:0]   = prescale_q;
    rdata                         = '0;
    if (hit) begin
      case (offset)
        TMR_CTRL:     rdata = {29'd0, irqen_q, reload_q, (state_q == ST_RUN)};
        TMR_PRESCALE: rdata = prescale_rd;
        TMR_COUNT:    rdata = count_q;
        TMR_COMPARE:  rdata = compare_q;
        TMR_STATUS:   rdata = {31'd0, match_q};
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer: a tick-countdown reference model checked
// every bus cycle, plus hand-computed literal expectations per scenario.
module tb_mips_timer;

  localparam logic [31:0] BASE       = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL     = BASE + 32'h00;
  localparam logic [31:0] A_PRESCALE = BASE + 32'h04;
  localparam logic [31:0] A_COUNT    = BASE + 32'h08;
  localparam logic [31:0] A_COMPARE  = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS   = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] memaddr = 32'd0;
  logic [31:0] memwritedata = 32'd0;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] ar_seq [7] = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0};
  logic [31:0] wr_seq [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd1};

  always #5 clk = ~clk;

  mips_timer #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .hit          (hit),
    .rdata        (rdata),
    .irq          (irq)
  );

  // Reference state; wait_n is the number of edges left until the next tick.
  typedef struct packed {
    logic        en;
    logic        reload;
    logic        irqen;
    logic [15:0] prescale;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
    logic [31:0] wait_n;
  } m_t;

  m_t m;

  function automatic m_t m_reset();
    m_t r;
    r.en = 1'b0; r.reload = 1'b0; r.irqen = 1'b0; r.prescale = 16'd0;
    r.count = 32'd0; r.compare = 32'hFFFF_FFFF; r.match = 1'b0; r.wait_n = 32'd0;
    return r;
  endfunction

  function automatic m_t model_next(input m_t s, input logic we, input logic [31:0] a,
                                    input logic [31:0] d);
    m_t   n;
    logic tk;
    logic hw;
    n  = s;
    tk = 1'b0;
    if (s.en) begin
      if (s.wait_n <= 32'd1) begin
        tk       = 1'b1;
        n.wait_n = {16'd0, s.prescale} + 32'd1;
      end else begin
        n.wait_n = s.wait_n - 32'd1;
      end
    end
    hw = we && (a[31:5] == BASE[31:5]);
    if (hw && a[4:2] == 3'd4 && d[0]) n.match = 1'b0;
    if (tk) begin
      if (s.count == s.compare) begin
        n.match = 1'b1;
        if (s.reload) n.count = 32'd0;
        else          n.en = 1'b0;
      end else begin
        n.count = s.count + 32'd1;
      end
    end
    if (hw) begin
      case (a[4:2])
        3'd0: begin
          n.en = d[0]; n.reload = d[1]; n.irqen = d[2];
          if (!s.en && d[0]) n.wait_n = {16'd0, s.prescale} + 32'd1;
        end
        3'd1: begin
          n.prescale = d[15:0];
          n.wait_n   = {16'd0, d[15:0]} + 32'd1;
        end
        3'd2: n.count = d;
        3'd3: n.compare = d;
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] model_rd(input m_t s, input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a[31:5] == BASE[31:5]) begin
      case (a[4:2])
        3'd0:    r = {29'd0, s.irqen, s.reload, s.en};
        3'd1:    r = {16'd0, s.prescale};
        3'd2:    r = s.count;
        3'd3:    r = s.compare;
        3'd4:    r = {31'd0, s.match};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= m_reset();
    else        m <= model_next(m, memwrite, memaddr, memwritedata);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic model_check();
    chk("model hit", {31'd0, hit}, {31'd0, (memaddr[31:5] == BASE[31:5])});
    chk("model rdata", rdata, model_rd(m, memaddr));
    chk("model irq", {31'd0, irq}, {31'd0, m.match & m.irqen});
  endtask

  // One bus cycle: drive just after the edge, check mid-cycle.
  task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    memwrite     = we;
    memaddr      = a;
    memwritedata = d;
    #3;
    if (we) $display("wr %08h <= %08h", a, d);
    else    $display("rd %08h -> %08h irq=%0d", a, rdata, irq);
    model_check();
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus(1'b0, a, 32'd0);
    chk(name, rdata, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    rd_chk("reset ctrl", A_CTRL, 32'd0);
    rd_chk("reset prescale", A_PRESCALE, 32'd0);
    rd_chk("reset count", A_COUNT, 32'd0);
    rd_chk("reset compare", A_COMPARE, 32'hFFFF_FFFF);
    rd_chk("reset status", A_STATUS, 32'd0);
    chk("reset irq", {31'd0, irq}, 32'd0);

    // One-shot: match exactly 20 edges after the CTRL write edge
    bus(1'b1, A_PRESCALE, 32'd3);
    bus(1'b1, A_COMPARE, 32'd4);
    bus(1'b1, A_CTRL, 32'd5);
    for (int k = 1; k <= 21; k++) begin
      rd_chk("oneshot match", A_STATUS, (k == 21) ? 32'd1 : 32'd0);
      chk("oneshot irq", {31'd0, irq}, (k == 21) ? 32'd1 : 32'd0);
    end
    rd_chk("oneshot count hold", A_COUNT, 32'd4);
    rd_chk("oneshot ctrl", A_CTRL, 32'd4);
    rd_chk("oneshot count still", A_COUNT, 32'd4);
    bus(1'b1, A_STATUS, 32'd1);
    bus(1'b1, A_COUNT, 32'd0);

    // Auto-reload with tick every cycle
    bus(1'b1, A_PRESCALE, 32'd0);
    bus(1'b1, A_COMPARE, 32'd2);
    bus(1'b1, A_CTRL, 32'd7);
    for (int k = 0; k < 7; k++) rd_chk("reload count", A_COUNT, ar_seq[k]);
    bus(1'b1, A_STATUS, 32'd1);
    rd_chk("w1c clears", A_STATUS, 32'd0);
    bus(1'b0, A_COUNT, 32'd0);
    bus(1'b1, A_STATUS, 32'd1);
    bus(1'b1, A_STATUS, 32'd1);
    rd_chk("w1c vs set", A_STATUS, 32'd1);
    bus(1'b1, A_CTRL, 32'd0);
    bus(1'b1, A_STATUS, 32'd1);

    // COUNT write on a tick edge
    bus(1'b1, A_COMPARE, 32'h1000);
    bus(1'b1, A_CTRL, 32'd1);
    bus(1'b0, A_COUNT, 32'd0);
    bus(1'b1, A_COUNT, 32'h100);
    rd_chk("count write vs tick", A_COUNT, 32'h100);
    rd_chk("count after write", A_COUNT, 32'h101);
    bus(1'b1, A_CTRL, 32'd0);

    // Asynchronous reset mid-run
    bus(1'b1, A_PRESCALE, 32'd100);
    bus(1'b1, A_COUNT, 32'd5);
    bus(1'b1, A_COMPARE, 32'd7);
    bus(1'b1, A_CTRL, 32'd7);
    repeat (3) bus(1'b0, A_COUNT, 32'd0);
    rd_chk("pre-reset count", A_COUNT, 32'd5);
    #1 reset = 1'b0;
    #1;
    chk("async count", rdata, 32'd0);
    chk("async irq", {31'd0, irq}, 32'd0);
    memaddr = A_COMPARE;
    #1;
    chk("async compare", rdata, 32'hFFFF_FFFF);
    repeat (2) bus(1'b0, A_COUNT, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 5; k++) rd_chk("no count after reset", A_COUNT, 32'd0);
    rd_chk("ctrl after reset", A_CTRL, 32'd0);

    // Wrap: FFFFFFFE -> FFFFFFFF -> 0 -> 1, match on the following tick
    bus(1'b1, A_COUNT, 32'hFFFF_FFFE);
    bus(1'b1, A_COMPARE, 32'd1);
    bus(1'b1, A_CTRL, 32'd5);
    for (int k = 0; k < 5; k++) begin
      rd_chk("wrap count", A_COUNT, wr_seq[k]);
      chk("wrap irq", {31'd0, irq}, (k == 4) ? 32'd1 : 32'd0);
    end
    rd_chk("wrap ctrl", A_CTRL, 32'd4);

    // Decode
    bus(1'b0, BASE + 32'h14, 32'd0);
    chk("decode 0x14 rdata", rdata, 32'd0);
    chk("decode 0x14 hit", {31'd0, hit}, 32'd1);
    bus(1'b0, BASE + 32'h20, 32'd0);
    chk("decode 0x20 rdata", rdata, 32'd0);
    chk("decode 0x20 hit", {31'd0, hit}, 32'd0);
    bus(1'b1, BASE + 32'h0E, 32'h1234_5678);
    rd_chk("decode compare", A_COMPARE, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_timer.md
# mips_timer

Memory-mapped timer peripheral that sits on the single-cycle MIPS CPU data bus as a responder. It decodes the CPU's `memwrite`/`memaddr`/`memwritedata` outputs, returns `memreaddata` for its register window, and counts prescaled clock ticks against a compare value. On a match it raises a sticky flag and an interrupt line. It sits beside data memory; the system-level read mux selects its `rdata` when `hit` is asserted.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: base byte address of the 32-byte register window; must be 32-byte aligned.
- `PRESCALE_W`, default 16: width of the prescaler divisor register.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserting it low forces the reset state immediately.
- `memwrite` in 1: CPU store strobe.
- `memaddr` in 32: CPU byte address.
- `memwritedata` in 32: CPU store data.
- `hit` out 1: `memaddr[31:5] == BASE_ADDR[31:5]`; combinational.
- `rdata` out 32: register read data; combinational; 0 when `hit`=0.
- `irq` out 1: `STATUS.match & CTRL.irqen`; combinational from registers.

## Operation
- Register map by offset (`memaddr[4:2]`; bits [1:0] are ignored):
  - 0x00 `CTRL` [0] `en`, [1] `reload`, [2] `irqen`; reads back all three bits.
  - 0x04 `PRESCALE` [PRESCALE_W-1:0].
  - 0x08 `COUNT` [31:0].
  - 0x0C `COMPARE` [31:0].
  - 0x10 `STATUS` [0] `match`. Writing 1 clears it; writing 0 has no effect.
- Offsets 0x14–0x1C read 0 and ignore writes.
- Write enable is `memwrite & hit`. All registers are written full-word; there are no byte enables.
- State machine has two states, derived from `CTRL.en`: `IDLE` (`en`=0) and `RUN` (`en`=1).
  - `IDLE`→`RUN`: write `CTRL` with `en`=1.
  - `RUN`→`IDLE`: write `CTRL` with `en`=0, or a match while `reload`=0 (one-shot; hardware clears `en`).
- Prescaler `pcnt` (PRESCALE_W bits) runs only in `RUN`.
  - A tick occurs when `pcnt == PRESCALE`; `pcnt` then returns to 0. Otherwise `pcnt` increments by 1.
  - `PRESCALE`=0 gives a tick every cycle.
  - `pcnt` is cleared on entry to `IDLE` and whenever `PRESCALE` is written.
- On a tick:
  - If `COUNT == COMPARE`: set `match`. If `reload`=1, `COUNT` becomes 0. If `reload`=0, `COUNT` holds and `en` clears.
  - Otherwise `COUNT` increments by 1, wrapping modulo 2^32 (0xFFFF_FFFF→0). Wrap alone does not set `match`.
- Simultaneous events:
  - CPU write to `COUNT` and a tick in the same cycle: the CPU write wins; no increment or reload.
  - CPU write to `CTRL` and a one-shot auto-clear of `en` in the same cycle: the CPU write wins.
  - Hardware set of `match` and a W1C write in the same cycle: the set wins; `match`=1.
  - Writing `COMPARE` during `RUN` takes effect for the next tick comparison.
- Reset values: `CTRL`=0, `PRESCALE`=0, `COUNT`=0, `COMPARE`=32'hFFFF_FFFF, `match`=0, `pcnt`=0. Consequently `irq`=0 and `rdata`=0 (given `hit`=0).
- Reset asserted mid-count aborts immediately. Counting resumes only after `en` is written again.

## Timing
- Reads have zero-cycle latency. `rdata` reflects register values at the current cycle, matching the CPU's single-cycle load expectation.
- Writes are visible on `rdata`/`irq` in the cycle after the store's rising edge.
- Tick period is `PRESCALE+1` cycles.
  - The first tick after `en` is written occurs `PRESCALE+1` edges after the write edge.
  - `match` and `irq` rise on the edge that processes the matching tick.
- One-shot match, counting from 0: with `COMPARE`=C and `PRESCALE`=P, `match` sets (C+1)·(P+1) cycles after the enable edge.
- Auto-reload period is (C+1)·(P+1) cycles.

## Structure
- Package `mips_timer_pkg` holds:
  - Register offset constants: `TMR_CTRL`, `TMR_PRESCALE`, `TMR_COUNT`, `TMR_COMPARE`, `TMR_STATUS`.
  - `CTRL` bit-index constants.
  - Reset value `COMPARE_RST`.
- One sub-module, `timer_prescaler`:
  - Parameter `PRESCALE_W`.
  - Inputs `clk`, `reset`, `run`, `clr`, `div`; output `tick`.
  - Contains `pcnt` and the terminal-count compare.
- Top level holds address decode, the register file, the count/compare logic and the read mux.

## Test plan
- Reset: pull `reset` low mid-run with `COUNT`=5. Required: `COUNT`=0, `COMPARE`=FFFF_FFFF, `irq`=0 asynchronously; no counting after release.
- One-shot: `PRESCALE`=3, `COMPARE`=4, `CTRL`=0x5. Required: `match`/`irq` rise exactly 20 cycles after the `CTRL` write edge; `COUNT` stays 4; `CTRL` reads 0x4.
- Auto-reload: `PRESCALE`=0, `COMPARE`=2, `CTRL`=0x7. Required: `match` after 3 cycles; `COUNT` sequence 1,2,0,1,2,0; W1C `STATUS`=1 clears `match` the next cycle.
- Collisions:
  - Write `COUNT`=0x100 on a tick edge. Required: reads 0x100.
  - W1C `STATUS` on the match edge. Required: `match` stays 1.
- Wrap: `COUNT`=FFFF_FFFE, `COMPARE`=1, `PRESCALE`=0, `en`=1. Required: `COUNT` goes FFFF_FFFF, then 0, then 1; `match` is set only on the tick after `COUNT` reaches 1.
- Decode: read at `BASE_ADDR`+0x14 and at `BASE_ADDR`+0x20. Required: `rdata`=0 for both; `hit`=1 then 0. Store to `BASE_ADDR`+0x0E. Required: updates `COMPARE`.
